// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Arbiter/sequencer for the unified multi-cycle memory shared by the IF and
// MEM pipeline stages. It grants one requester at a time, holds the memory
// transaction until m_ready, returns registered read data plus a one-cycle
// done pulse to the winner, and drives the IF / MEM stall signals.
//
// Optional feature macro: MEM_ARB_ALIGN_CHK_EN
//   defined   -> a granted request with address bit 0 set skips memory and
//                completes immediately with err=1 and its done pulse
//   undefined -> err is tied to 0
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   if_req/if_addr         instruction fetch request and PC
//   if_flush               taken branch/jump, cancels the pending fetch
//   mem_rd/mem_wr          MEM stage load/store request (mutually exclusive)
//   mem_addr/mem_wdata     data address / store data
//   m_rdata/m_ready        memory read data and completion pulse
//   m_en/m_wr              memory start strobe / write select
//   m_addr/m_wdata         latched transaction address / write data
//   if_data/mem_rdata      registered read data per requester
//   if_done/mem_done       one-cycle completion pulses
//   stall_if/stall_mem     stage stalls for the hazard unit
//   err                    misaligned-access pulse
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              m_en,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] if_data,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              if_done,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DATA,
        S_RESP_F,
        S_RESP_D
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_first;      // first cycle of FETCH/DATA, drives m_en
    logic              r_discard;    // fetch cancelled by a flush while in flight
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_rdata;

    logic              w_data_req;
    logic              w_fetch_req;
    logic              w_grant;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_misalign;

    // Data wins arbitration: the MEM-stage instruction is older than the fetch.
    assign w_data_req  = mem_rd | mem_wr;
    assign w_fetch_req = if_req & ~if_flush;
    assign w_grant     = (r_state == S_IDLE) & (w_data_req | w_fetch_req);
    assign w_req_addr  = w_data_req ? mem_addr : if_addr;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign w_misalign = w_req_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    // ---------------- state register ----------------
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: assign a default before the case so no path leaves the
        // signal unassigned and a latch is never inferred.
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_data_req) begin
                    w_state_nxt = w_misalign ? S_RESP_D : S_DATA;
                end else if (w_fetch_req) begin
                    w_state_nxt = w_misalign ? S_RESP_F : S_FETCH;
                end
            end
            S_FETCH: begin
                if (m_ready) begin
                    w_state_nxt = r_discard ? S_IDLE : S_RESP_F;
                end
            end
            S_DATA: begin
                if (m_ready) begin
                    w_state_nxt = S_RESP_D;
                end
            end
            // Requests are not re-arbitrated here: the stage still presents
            // the request it has just been served until it advances.
            S_RESP_F, S_RESP_D: w_state_nxt = S_IDLE;
            default:            w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        m_en     = r_first;
        if_done  = (r_state == S_RESP_F);
        mem_done = (r_state == S_RESP_D);
    end

    assign m_wr      = r_wr;
    assign m_addr    = r_addr;
    assign m_wdata   = r_wdata;
    assign if_data   = r_if_data;
    assign mem_rdata = r_mem_rdata;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = w_data_req & ~mem_done;

    // ---------------- transaction datapath ----------------
    // NOTE: the read-data holding registers are reset along with the control
    // flops because their zero value after reset is visible to the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first     <= 1'b0;
            r_discard   <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_first <= 1'b0;

            // Address, write data and direction are captured on the grant
            // edge and held for the whole transaction.
            if (w_grant) begin
                r_addr  <= w_req_addr;
                r_wr    <= mem_wr;
                r_first <= ~w_misalign;
                if (w_data_req) begin
                    r_wdata <= mem_wdata;
                end
            end

            if (r_state == S_FETCH) begin
                if (if_flush) begin
                    r_discard <= 1'b1;
                end
                if (m_ready) begin
                    r_discard <= 1'b0;
                    if (!r_discard) begin
                        r_if_data <= m_rdata;
                    end
                end
            end

            // Stores complete without touching the load data register.
            if ((r_state == S_DATA) && m_ready && !r_wr) begin
                r_mem_rdata <= m_rdata;
            end
        end
    end

`ifdef MEM_ARB_ALIGN_CHK_EN
    logic r_err;

    // err coincides with the done pulse of a misaligned, memory-less grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_grant & w_misalign;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. Inputs are driven and outputs sampled
// on the falling clock edge. A transaction-level reference (a sparse memory
// image plus the expected registered read data) predicts every result; the
// cycle at which each event must appear follows from the request/grant/
// m_ready/done timeline of the arbiter.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              m_en;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] if_data;
    logic [DATA_W-1:0] mem_rdata;
    logic              if_done;
    logic              mem_done;
    logic              stall_if;
    logic              stall_mem;
    logic              err;

    mem_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .m_en      (m_en),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .if_data   (if_data),
        .mem_rdata (mem_rdata),
        .if_done   (if_done),
        .mem_done  (mem_done),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: memory image and expected registered read data.
    logic [15:0] mem_model [logic [15:0]];
    logic [15:0] exp_if_data   = 16'h0000;
    logic [15:0] exp_mem_rdata = 16'h0000;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[7:0] ^ 8'h3C, ~a[7:0]};
    endfunction

    task automatic req_fetch(input logic [15:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic req_data(input bit wr, input logic [15:0] a, input logic [15:0] d);
        mem_rd    = ~wr;
        mem_wr    = wr;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    // One IDLE cycle: nothing may start or complete. A stray m_ready is
    // thrown in; the arbiter must ignore it.
    task automatic idle_tick();
        @(negedge clk);
        if_flush = 1'b0;
        check("idle_m_en", m_en, 0);
        check("idle_done", {if_done, mem_done}, 0);
        check("idle_err", err, 0);
        m_ready = 1'($urandom);
        m_rdata = 16'($urandom);
    endtask

    // Serve one transaction whose request is already presented in the
    // current (IDLE) cycle t. Grant/m_en in t+1, m_ready lat cycles later
    // (cycle k), done in k+1. flush_off>0 raises if_flush that many cycles
    // after the grant cycle (fetch only, flush_off < lat).
    task automatic serve(input bit is_data, input bit is_wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input int lat, input int flush_off);
        logic [15:0] rd;
        bit          disc;
        disc = 1'b0;
        rd   = model_rd(addr);

        @(negedge clk);
        m_ready = 1'b0;
        m_rdata = 16'($urandom);
        check("grant_m_en", m_en, 1);
        check("grant_m_addr", m_addr, addr);
        check("grant_m_wr", m_wr, is_wr);
        if (is_wr) check("grant_m_wdata", m_wdata, wdata);
        check("grant_done", {if_done, mem_done}, 0);

        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if_flush = 1'b0;
            check("busy_m_en", m_en, 0);
            check("busy_m_addr", m_addr, addr);
            check("busy_m_wr", m_wr, is_wr);
            if (is_wr) check("busy_m_wdata", m_wdata, wdata);
            check("busy_done", {if_done, mem_done}, 0);
            if (is_data) check("busy_stall_mem", stall_mem, 1);
            else if (!disc) check("busy_stall_if", stall_if, 1);
            if (!is_data && c == flush_off) begin
                if_flush = 1'b1;
                if_req   = 1'b0;
                disc     = 1'b1;
            end
            if (c == lat) begin
                m_ready = 1'b1;
                m_rdata = rd;
            end else begin
                m_rdata = 16'($urandom);
            end
        end

        @(negedge clk);
        m_ready  = 1'b0;
        if_flush = 1'b0;
        m_rdata  = 16'($urandom);
        check("resp_m_en", m_en, 0);
        if (is_data) begin
            if (is_wr) mem_model[addr] = wdata;
            else exp_mem_rdata = rd;
            check("resp_mem_done", mem_done, 1);
            check("resp_if_done", if_done, 0);
            check("resp_stall_mem", stall_mem, 0);
            if (if_req) check("resp_stall_if_wait", stall_if, 1);
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end else if (disc) begin
            check("flush_done", {if_done, mem_done}, 0);
        end else begin
            exp_if_data = rd;
            check("resp_if_done", if_done, 1);
            check("resp_mem_done", mem_done, 0);
            check("resp_stall_if", stall_if, 0);
            if_req = 1'b0;
        end
        check("if_data", if_data, exp_if_data);
        check("mem_rdata", mem_rdata, exp_mem_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        m_rdata   = '0;
        m_ready   = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_m_en", m_en, 0);
        check("rst_m_wr", m_wr, 0);
        check("rst_done", {if_done, mem_done}, 0);
        check("rst_err", err, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_if_data", if_data, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fetch alone, m_ready three cycles after m_en.
        mem_model[16'h0010] = 16'hA5A5;
        req_fetch(16'h0010);
        serve(1'b0, 1'b0, 16'h0010, 16'h0000, 3, 0);
        idle_tick();

        // Store then load back the stored word.
        req_data(1'b1, 16'h0100, 16'h1234);
        serve(1'b1, 1'b1, 16'h0100, 16'h1234, 4, 0);
        idle_tick();
        req_data(1'b0, 16'h0100, 16'h0000);
        serve(1'b1, 1'b0, 16'h0100, 16'h0000, 2, 0);
        idle_tick();

        // Simultaneous fetch and load: data first, fetch m_en two cycles
        // after mem_done.
        req_fetch(16'h0020);
        req_data(1'b0, 16'h0040, 16'h0000);
        serve(1'b1, 1'b0, 16'h0040, 16'h0000, 2, 0);
        idle_tick();
        serve(1'b0, 1'b0, 16'h0020, 16'h0000, 1, 0);
        idle_tick();

        // Flush one cycle after the fetch grant; back in IDLE right after
        // m_ready, so a new fetch presented then is granted at once.
        req_fetch(16'h0030);
        serve(1'b0, 1'b0, 16'h0030, 16'h0000, 3, 1);
        req_fetch(16'h0032);
        serve(1'b0, 1'b0, 16'h0032, 16'h0000, 1, 0);
        idle_tick();

        // Reset in the middle of a store.
        req_data(1'b1, 16'h0044, 16'h5555);
        @(negedge clk);
        m_ready = 1'b0;
        check("midrst_m_en", m_en, 1);
        check("midrst_m_wr", m_wr, 1);
        @(negedge clk);
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        rst    = 1'b1;
        #1;
        check("midrst_m_en0", m_en, 0);
        check("midrst_m_wr0", m_wr, 0);
        check("midrst_done0", {if_done, mem_done}, 0);
        check("midrst_err0", err, 0);
        check("midrst_m_addr0", m_addr, 0);
        check("midrst_m_wdata0", m_wdata, 0);
        check("midrst_if_data0", if_data, 0);
        check("midrst_mem_rdata0", mem_rdata, 0);
        exp_if_data   = 16'h0000;
        exp_mem_rdata = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        m_rdata = 16'hBEEF;
        @(negedge clk);
        m_ready = 1'b0;
        check("late_ready_done", {if_done, mem_done}, 0);
        @(negedge clk);
        check("late_ready_done2", {if_done, mem_done}, 0);
        check("late_ready_m_en", m_en, 0);
        check("late_ready_mem_rdata", mem_rdata, 0);

`ifdef MEM_ARB_ALIGN_CHK_EN
        // Misaligned load and fetch: no memory access, err with done.
        req_data(1'b0, 16'h0003, 16'h0000);
        @(negedge clk);
        mem_rd = 1'b0;
        check("mis_m_en", m_en, 0);
        check("mis_err", err, 1);
        check("mis_mem_done", mem_done, 1);
        check("mis_mem_rdata", mem_rdata, exp_mem_rdata);
        idle_tick();
        req_fetch(16'h0011);
        @(negedge clk);
        if_req = 1'b0;
        check("misf_m_en", m_en, 0);
        check("misf_err", err, 1);
        check("misf_if_done", if_done, 1);
        check("misf_if_data", if_data, exp_if_data);
        idle_tick();
`endif

        // Randomized mix of transactions.
        for (int i = 0; i < 150; i++) begin
            int          sc;
            int          lat;
            int          fo;
            logic [15:0] a;
            logic [15:0] a2;
            logic [15:0] d;
            sc  = int'($urandom_range(0, 4));
            lat = int'($urandom_range(1, 4));
            a   = 16'($urandom_range(0, 63));
            a2  = 16'($urandom_range(0, 63));
            d   = 16'($urandom);
`ifdef MEM_ARB_ALIGN_CHK_EN
            a[0]  = 1'b0;
            a2[0] = 1'b0;
`endif
            case (sc)
                0: begin
                    req_fetch(a);
                    serve(1'b0, 1'b0, a, 16'h0000, lat, 0);
                end
                1: begin
                    req_data(1'b0, a, 16'h0000);
                    serve(1'b1, 1'b0, a, 16'h0000, lat, 0);
                end
                2: begin
                    req_data(1'b1, a, d);
                    serve(1'b1, 1'b1, a, d, lat, 0);
                end
                3: begin
                    if (lat < 2) lat = 2;
                    fo = int'($urandom_range(1, lat - 1));
                    req_fetch(a);
                    serve(1'b0, 1'b0, a, 16'h0000, lat, fo);
                end
                default: begin
                    req_fetch(a2);
                    req_data(1'b0, a, 16'h0000);
                    serve(1'b1, 1'b0, a, 16'h0000, lat, 0);
                    idle_tick();
                    serve(1'b0, 1'b0, a2, 16'h0000, int'($urandom_range(1, 4)), 0);
                end
            endcase
            idle_tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
